// File: rtl/branch_ctrl_if.sv
// Decode-to-branch-controller handshake bundle: one branch per valid/ready beat.
interface branch_ctrl_if;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  br_op;
  logic [31:0] br_rs1;
  logic [31:0] br_rs2;
  logic [31:0] br_pc;
  logic [31:0] br_offset;
  logic        br_pred_taken;

  modport master (
    output br_valid, br_op, br_rs1, br_rs2, br_pc, br_offset, br_pred_taken,
    input  br_ready
  );

  modport slave (
    input  br_valid, br_op, br_rs1, br_rs2, br_pc, br_offset, br_pred_taken,
    output br_ready
  );
endinterface

// File: rtl/branch_ctrl.sv
// Conditional-branch sequencer: drives the compare unit, resolves against the
// prediction, redirects fetch and flushes on mispredict. Optional statistics
// counters are built only when BRANCH_CTRL_STATS_EN is defined.
module branch_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic          CLK,
  input  logic          RST,
  branch_ctrl_if.slave  br,
  output logic [31:0]   cmp_rs1,
  output logic [31:0]   cmp_rs2,
  output logic [2:0]    cmp_op,
  input  logic          cmp_br_en,
  output logic          res_valid,
  output logic          res_taken,
  output logic          res_illegal,
  output logic          redirect_valid,
  output logic [31:0]   redirect_pc,
  output logic          flush,
  input  logic          stat_clr,
  output logic [31:0]   stat_branches,
  output logic [31:0]   stat_mispredicts
);

  typedef enum logic [1:0] {IDLE, EVAL, RESOLVE, FLUSH} state_t;

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  state_t      state;
  logic [3:0]  flush_cnt;
  logic [31:0] pc_q;
  logic [31:0] offset_q;
  logic        pred_q;
  logic        mispred_q;

  // The operand registers double as the compare-unit drive, so in EVAL
  // cmp_op is the captured op and can be decoded for legality directly.
  logic        illegal_now;
  logic        taken_now;
  logic        mispred_now;
  logic [31:0] target_now;

  assign illegal_now = (cmp_op > 3'b101);
  assign taken_now   = cmp_br_en & ~illegal_now;
  assign mispred_now = (taken_now != pred_q);
  assign target_now  = (taken_now ? (pc_q + offset_q) : (pc_q + 32'd4)) & ~32'd1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= IDLE;
      flush_cnt      <= 4'd0;
      pc_q           <= 32'd0;
      offset_q       <= 32'd0;
      pred_q         <= 1'b0;
      mispred_q      <= 1'b0;
      cmp_rs1        <= 32'd0;
      cmp_rs2        <= 32'd0;
      cmp_op         <= 3'd0;
      br.br_ready    <= 1'b1;
      res_valid      <= 1'b0;
      res_taken      <= 1'b0;
      res_illegal    <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
      flush          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (br.br_valid) begin
            cmp_rs1     <= br.br_rs1;
            cmp_rs2     <= br.br_rs2;
            cmp_op      <= br.br_op;
            pc_q        <= br.br_pc;
            offset_q    <= br.br_offset;
            pred_q      <= br.br_pred_taken;
            br.br_ready <= 1'b0;
            state       <= EVAL;
          end
        end

        EVAL: begin
          mispred_q   <= mispred_now;
          res_valid   <= 1'b1;
          res_taken   <= taken_now;
          res_illegal <= illegal_now;
          cmp_rs1     <= 32'd0;
          cmp_rs2     <= 32'd0;
          cmp_op      <= 3'd0;
          if (mispred_now) begin
            redirect_valid <= 1'b1;
            redirect_pc    <= target_now;
            flush          <= 1'b1;
          end
          state <= RESOLVE;
        end

        RESOLVE: begin
          res_valid      <= 1'b0;
          res_taken      <= 1'b0;
          res_illegal    <= 1'b0;
          redirect_valid <= 1'b0;
          if (mispred_q && (FLUSH_CYCLES > 1)) begin
            flush_cnt <= 4'd1;
            state     <= FLUSH;
          end else begin
            flush       <= 1'b0;
            br.br_ready <= 1'b1;
            state       <= IDLE;
          end
        end

        FLUSH: begin
          // RESOLVE already supplied the first flush cycle.
          if (flush_cnt == FLUSH_LAST) begin
            flush_cnt   <= 4'd0;
            flush       <= 1'b0;
            br.br_ready <= 1'b1;
            state       <= IDLE;
          end else begin
            flush_cnt <= flush_cnt + 4'd1;
          end
        end

        default: begin
          state       <= IDLE;
          br.br_ready <= 1'b1;
          flush       <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRANCH_CTRL_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST || stat_clr) begin
      stat_branches    <= 32'd0;
      stat_mispredicts <= 32'd0;
    end else begin
      if (res_valid && (stat_branches != 32'hFFFF_FFFF))
        stat_branches <= stat_branches + 32'd1;
      if (redirect_valid && (stat_mispredicts != 32'hFFFF_FFFF))
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`else
  logic unused_stat_clr;
  assign unused_stat_clr  = stat_clr;
  assign stat_branches    = 32'd0;
  assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed cases plus randomized branches
// checked against a behavioural outcome model, with a stand-in compare unit.
module tb_branch_ctrl;

  localparam int FC = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] cmp_rs1, cmp_rs2;
  logic [2:0]  cmp_op;
  logic        cmp_br_en;
  logic        res_valid, res_taken, res_illegal;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        stat_clr;
  logic [31:0] stat_branches, stat_mispredicts;

  int checks = 0;
  int errors = 0;
  logic [31:0] expBranches = 32'd0;
  logic [31:0] expMispredicts = 32'd0;

  branch_ctrl_if bif ();

  branch_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .br               (bif),
    .cmp_rs1          (cmp_rs1),
    .cmp_rs2          (cmp_rs2),
    .cmp_op           (cmp_op),
    .cmp_br_en        (cmp_br_en),
    .res_valid        (res_valid),
    .res_taken        (res_taken),
    .res_illegal      (res_illegal),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .flush            (flush),
    .stat_clr         (stat_clr),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  always #5 CLK = ~CLK;

  // Stand-in compare unit built from a borrow-based subtract; it answers 1
  // for undefined ops so the controller's not-taken forcing is exercised.
  function automatic logic cmpUnit(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] diff;
    logic ltu, lts;
    diff = {1'b0, a} - {1'b0, b};
    ltu  = diff[32];
    lts  = (a[31] != b[31]) ? a[31] : ltu;
    case (op)
      3'd0:    cmpUnit = (diff[31:0] == 32'd0);
      3'd1:    cmpUnit = (diff[31:0] != 32'd0);
      3'd2:    cmpUnit = lts;
      3'd3:    cmpUnit = ltu;
      3'd4:    cmpUnit = ~lts;
      3'd5:    cmpUnit = ~ltu;
      default: cmpUnit = 1'b1;
    endcase
  endfunction

  always_comb cmp_br_en = cmpUnit(cmp_op, cmp_rs1, cmp_rs2);

  // Architectural branch outcome from the instruction fields alone.
  function automatic logic refTaken(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    refTaken = (a == b);
      3'd1:    refTaken = (a != b);
      3'd2:    refTaken = ($signed(a) <  $signed(b));
      3'd3:    refTaken = (a <  b);
      3'd4:    refTaken = ($signed(a) >= $signed(b));
      3'd5:    refTaken = (a >= b);
      default: refTaken = 1'b0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] pc, input logic [31:0] off, input logic pred);
    bif.br_valid      = 1'b1;
    bif.br_op         = op;
    bif.br_rs1        = a;
    bif.br_rs2        = b;
    bif.br_pc         = pc;
    bif.br_offset     = off;
    bif.br_pred_taken = pred;
  endtask

  task automatic checkStats();
    checkOutput("stat_branches", stat_branches, expBranches);
    checkOutput("stat_mispredicts", stat_mispredicts, expMispredicts);
  endtask

  task automatic runBranch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] pc, input logic [31:0] off, input logic pred,
                           input bit clrAtResolve, input bit rstAtResolve);
    logic        expTaken, expIll, expMis;
    logic [31:0] expPc;
    int          n;
    expIll   = (op > 3'd5);
    expTaken = expIll ? 1'b0 : refTaken(op, a, b);
    expMis   = (expTaken != pred);
    expPc    = (expTaken ? (pc + off) : (pc + 32'd4)) & ~32'd1;

    n = 0;
    while (bif.br_ready !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("ready_before_accept", {31'd0, bif.br_ready}, 32'd1);

    applyStimulus(op, a, b, pc, off, pred);
    @(posedge CLK);
    #1 bif.br_valid = 1'b0;

    @(negedge CLK);
    checkOutput("eval_ready", {31'd0, bif.br_ready}, 32'd0);
    checkOutput("eval_cmp_op", {29'd0, cmp_op}, {29'd0, op});
    checkOutput("eval_cmp_rs1", cmp_rs1, a);
    checkOutput("eval_cmp_rs2", cmp_rs2, b);
    checkOutput("eval_res_valid", {31'd0, res_valid}, 32'd0);

    @(negedge CLK);
    checkOutput("res_valid", {31'd0, res_valid}, 32'd1);
    checkOutput("res_taken", {31'd0, res_taken}, {31'd0, expTaken});
    checkOutput("res_illegal", {31'd0, res_illegal}, {31'd0, expIll});
    checkOutput("redirect_valid", {31'd0, redirect_valid}, {31'd0, expMis});
    checkOutput("resolve_flush", {31'd0, flush}, {31'd0, expMis});
    checkOutput("resolve_ready", {31'd0, bif.br_ready}, 32'd0);
    if (expMis) checkOutput("redirect_pc", redirect_pc, expPc);

    if (clrAtResolve) stat_clr = 1'b1;
    if (rstAtResolve) RST = 1'b1;
    @(posedge CLK);
    #1;
    stat_clr = 1'b0;
    RST      = 1'b0;

    if (rstAtResolve) begin
      expBranches    = 32'd0;
      expMispredicts = 32'd0;
    end else begin
`ifdef BRANCH_CTRL_STATS_EN
      if (clrAtResolve) begin
        expBranches    = 32'd0;
        expMispredicts = 32'd0;
      end else begin
        expBranches = expBranches + 32'd1;
        if (expMis) expMispredicts = expMispredicts + 32'd1;
      end
`endif
    end

    if (rstAtResolve) begin
      @(negedge CLK);
      checkOutput("rst_flush", {31'd0, flush}, 32'd0);
      checkOutput("rst_ready", {31'd0, bif.br_ready}, 32'd1);
      checkOutput("rst_redirect", {31'd0, redirect_valid}, 32'd0);
      checkOutput("rst_redirect_pc", redirect_pc, 32'd0);
      checkOutput("rst_res_valid", {31'd0, res_valid}, 32'd0);
      checkStats();
      @(negedge CLK);
      checkOutput("rst_flush_later", {31'd0, flush}, 32'd0);
      checkOutput("rst_redirect_later", {31'd0, redirect_valid}, 32'd0);
    end else begin
      for (int i = 0; i < (expMis ? FC - 1 : 0); i++) begin
        @(negedge CLK);
        checkOutput("flush_hold", {31'd0, flush}, 32'd1);
        checkOutput("flush_ready", {31'd0, bif.br_ready}, 32'd0);
        checkOutput("flush_redirect", {31'd0, redirect_valid}, 32'd0);
        checkOutput("flush_res_valid", {31'd0, res_valid}, 32'd0);
      end
      @(negedge CLK);
      checkOutput("idle_flush", {31'd0, flush}, 32'd0);
      checkOutput("idle_ready", {31'd0, bif.br_ready}, 32'd1);
      checkOutput("idle_cmp_op", {29'd0, cmp_op}, 32'd0);
      checkOutput("idle_res_valid", {31'd0, res_valid}, 32'd0);
      if (expMis) checkOutput("redirect_pc_hold", redirect_pc, expPc);
      checkStats();
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired before completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [2:0]  rOp;
    logic [31:0] rA, rB, rPc, rOff;
    logic        rPred;

    RST          = 1'b1;
    stat_clr     = 1'b0;
    bif.br_valid = 1'b0;
    applyStimulus(3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    bif.br_valid = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    checkOutput("reset_ready", {31'd0, bif.br_ready}, 32'd1);
    checkOutput("reset_res_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("reset_flush", {31'd0, flush}, 32'd0);
    checkOutput("reset_redirect", {31'd0, redirect_valid}, 32'd0);
    checkOutput("reset_redirect_pc", redirect_pc, 32'd0);
    checkOutput("reset_cmp_rs1", cmp_rs1, 32'd0);
    checkStats();

    // Three branches, one mispredicted.
    runBranch(3'b000, 32'h5, 32'h5, 32'h100, 32'h20, 1'b1, 1'b0, 1'b0);
    runBranch(3'b010, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0);
    runBranch(3'b001, 32'h7, 32'h9, 32'h300, 32'h40, 1'b1, 1'b0, 1'b0);
    checkOutput("three_branch_count", stat_branches, expBranches);

    runBranch(3'b101, 32'h1, 32'h2, 32'hFFFF_FFFC, 32'h80, 1'b1, 1'b0, 1'b0);
    runBranch(3'b111, 32'h3, 32'h3, 32'h400, 32'h10, 1'b1, 1'b0, 1'b0);
    runBranch(3'b110, 32'h3, 32'h4, 32'h500, 32'h10, 1'b0, 1'b0, 1'b0);
    runBranch(3'b100, 32'h8000_0000, 32'h1, 32'h600, 32'h100, 1'b1, 1'b1, 1'b0);
    runBranch(3'b011, 32'h1, 32'hFFFF_FFFF, 32'h700, 32'h33, 1'b0, 1'b0, 1'b0);
    runBranch(3'b010, 32'h1, 32'h2, 32'h800, 32'h8, 1'b0, 1'b0, 1'b1);

    for (int k = 0; k < 40; k++) begin
      rOp   = 3'($urandom_range(0, 7));
      rA    = $urandom;
      rB    = ($urandom_range(0, 3) == 0) ? rA : $urandom;
      rPc   = $urandom;
      rOff  = $urandom;
      rPred = 1'($urandom_range(0, 1));
      runBranch(rOp, rA, rB, rPc, rOff, rPred, ($urandom_range(0, 9) == 0), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Sequences the branch-compare unit for conditional branches (BEQ/BNE/BLT/BLTU/BGE/BGEU).
- Accepts one branch from decode per valid/ready handshake and drives the compare unit's operands and op code. Samples the taken flag it returns.
- Compares that flag against the front-end prediction. On mispredict, issues a PC redirect and a multi-cycle pipeline flush.
- Sits between decode/issue and fetch; owns the single compare unit.

Parameters:
- FLUSH_CYCLES, 2, total cycles `flush` stays high per mispredict; legal range 1..15.

Ports:
- CLK  input  1  core clock; all state changes on rising edge.
- RST  input  1  reset; synchronous, active-high.
- br_valid  input  1  decode presents a branch.
- br_ready  output  1  controller can accept a branch.
- br_op  input  3  compare op: 000 BEQ, 001 BNE, 010 BLT, 011 BLTU, 100 BGE, 101 BGEU.
- br_rs1, br_rs2  input  32  source operand values.
- br_pc  input  32  PC of the branch.
- br_offset  input  32  sign-extended branch immediate.
- br_pred_taken  input  1  front-end prediction.
- cmp_rs1, cmp_rs2  output  32  operands to the compare unit.
- cmp_op  output  3  op to the compare unit.
- cmp_br_en  input  1  taken flag from the compare unit (combinational).
- res_valid  output  1  one-cycle resolution pulse.
- res_taken  output  1  actual outcome; valid while res_valid is high.
- res_illegal  output  1  br_op was 110/111; valid while res_valid is high.
- redirect_valid  output  1  one-cycle fetch redirect.
- redirect_pc  output  32  corrected fetch PC.
- flush  output  1  kill younger in-flight instructions.
- stat_clr  input  1  clear statistics counters (optional feature only).
- stat_branches, stat_mispredicts  output  32  statistics counters.

Behaviour:
- States: IDLE, EVAL, RESOLVE, FLUSH. A 4-bit flush counter holds the FLUSH count.
- Reset (RST high at an edge), including mid-operation:
  - state goes to IDLE; all captured registers go to 0;
  - br_ready=1 after reset; res_valid, res_taken, res_illegal, redirect_valid, flush, cmp_* all 0; redirect_pc=0;
  - a pending redirect or flush is abandoned.
- IDLE:
  - br_ready=1 (a decode of state only; no combinational path from br_valid);
  - on br_valid & br_ready, capture op, rs1, rs2, pc, offset and pred, then go to EVAL.
- EVAL (1 cycle):
  - cmp_rs1/cmp_rs2/cmp_op driven from captured registers; zero outside EVAL;
  - at the edge, register taken=cmp_br_en, illegal=(op>3'b101), mispredict=(taken != pred);
  - an illegal op is forced not-taken regardless of cmp_br_en;
  - go to RESOLVE.
- RESOLVE (1 cycle):
  - res_valid=1 with res_taken and res_illegal;
  - if mispredict: redirect_valid=1 and flush=1, with redirect_pc = taken ? (pc+offset) : (pc+32'd4);
  - redirect_pc is modulo 2^32 (wrap-around, no overflow flag) and bit 0 is forced to 0;
  - next state: mispredict & FLUSH_CYCLES>1 goes to FLUSH with counter=1; otherwise IDLE.
- FLUSH:
  - flush=1 and br_ready=0; counter increments each cycle;
  - when counter==FLUSH_CYCLES-1, go to IDLE;
  - total flush-high cycles = FLUSH_CYCLES.
- br_ready=0 in EVAL, RESOLVE and FLUSH; br_valid in these states is ignored, and decode must hold it.
- Latency: accept edge T; EVAL at T+1; RESOLVE/res_valid/redirect at T+2; earliest next accept is the edge ending T+3 (no mispredict). Throughput: 1 branch per 3 cycles without mispredict.
- Correct prediction produces no redirect and no flush.
- redirect_pc holds its last value outside RESOLVE; consumers qualify it with redirect_valid.

Optional Feature:
- Macro: BRANCH_CTRL_STATS_EN.
- Defined:
  - stat_branches increments by 1 on every res_valid;
  - stat_mispredicts increments on every redirect_valid;
  - both counters saturate at 32'hFFFFFFFF;
  - stat_clr (synchronous) zeroes both counters and takes priority over an increment in the same cycle;
  - RST zeroes both counters.
- Not defined: ports still exist; stat_* tied to 0; stat_clr ignored; no counter flops.

Test Plan:
- BEQ, rs1=rs2=32'h5, pc=32'h100, offset=32'h20, pred=1 -> res_valid at T+2, res_taken=1, no redirect, no flush, br_ready=1 at T+3.
- BLT, rs1=32'hFFFFFFFF, rs2=32'h1, pc=32'h200, offset=32'hFFFFFFF0, pred=0 -> redirect_valid 1 cycle, redirect_pc=32'h1F0, flush high exactly 2 cycles, br_ready=0 throughout.
- BGEU, rs1=32'h1, rs2=32'h2, pred=1, pc=32'hFFFFFFFC -> not-taken mispredict, redirect_pc=32'h0 (wrap).
- br_op=3'b111, pred=1 -> res_illegal=1, res_taken=0, redirect to pc+4.
- RST asserted during FLUSH -> next cycle flush=0, state IDLE, br_ready=1, no further redirect; with BRANCH_CTRL_STATS_EN, counters read 0.
- With BRANCH_CTRL_STATS_EN: 3 branches (1 mispredict) -> stat_branches=3, stat_mispredicts=1; stat_clr coincident with a res_valid -> both 0.
